smbm_metric_list: RTL and testbench

- Sorted metric buffer for one metric: the responder side of the metric-list interface consumed by the filter/predicate unit.
- Holds up to BIT_VEC_SIZE entries {ptr, val}, sorted ascending by val. Empty slots carry ptr = all-ones and occupy the tail.
- Accepts read, insert, delete and update requests from the control path.
- Drives the full sorted list as a flat bus to the filter unit, plus a per-request response.

---
 rtl/smbm_metric_list.sv | 224 ++++++++++++++++++++++
 tb/tb_smbm_metric_list.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/smbm_metric_list.sv
// ---------------------------------------------------------------------------
// smbm_metric_list
//   Sorted metric buffer for a single metric. Holds up to BIT_VEC_SIZE
//   {ptr, val} entries kept ascending by val, with empty slots
//   (ptr = all-ones) packed at the tail. Serves read / insert / delete /
//   update requests from the control path and exposes the whole sorted list
//   to the filter unit as a flat bus.
//
// Ports
//   clk, rst    clock; asynchronous active-low reset
//   req_valid   request present
//   req_ready   request accepted on req_valid & req_ready (low in UPD_INS)
//   req_op      00 read, 01 insert, 10 delete, 11 update
//   req_id      ptr operated on (insert/delete/update)
//   req_val     metric value (insert/update)
//   list_out    slot i at [i*(LOG+VAL_W) +: LOG+VAL_W], {ptr, val}
//   count       number of occupied slots
//   resp_valid  one-cycle pulse per completed request
//   resp_err    qualifies resp_valid; request rejected, list unchanged
// ---------------------------------------------------------------------------
module smbm_metric_list #(
  parameter int BIT_VEC_SIZE     = 512,
  parameter int BIT_VEC_SIZE_LOG = 9,
  parameter int VAL_W            = 16
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             req_valid,
  output logic                                             req_ready,
  input  logic [1:0]                                       req_op,
  input  logic [BIT_VEC_SIZE_LOG-1:0]                      req_id,
  input  logic [VAL_W-1:0]                                 req_val,
  output logic [BIT_VEC_SIZE*(BIT_VEC_SIZE_LOG+VAL_W)-1:0] list_out,
  output logic [BIT_VEC_SIZE_LOG:0]                        count,
  output logic                                             resp_valid,
  output logic                                             resp_err
);

  localparam int SLOT_W = BIT_VEC_SIZE_LOG + VAL_W;
  localparam logic [BIT_VEC_SIZE_LOG-1:0] EMPTY_PTR = '1;

  typedef struct packed {
    logic [BIT_VEC_SIZE_LOG-1:0] ptr;
    logic [VAL_W-1:0]            val;
  } slot_t;

  localparam slot_t EMPTY_SLOT = slot_t'({EMPTY_PTR, {VAL_W{1'b0}}});

  typedef enum logic [1:0] {
    OP_READ   = 2'b00,
    OP_INSERT = 2'b01,
    OP_DELETE = 2'b10,
    OP_UPDATE = 2'b11
  } op_t;

  typedef enum logic {
    S_IDLE,
    S_UPD_INS
  } state_t;

  state_t                      state_q, state_d;
  slot_t                       slot_q [BIT_VEC_SIZE];
  slot_t                       slot_d [BIT_VEC_SIZE];
  slot_t                       ins_slots [BIT_VEC_SIZE];
  slot_t                       del_slots [BIT_VEC_SIZE];
  logic [BIT_VEC_SIZE_LOG:0]   count_q, count_d;
  logic                        resp_valid_q, resp_valid_d;
  logic                        resp_err_q, resp_err_d;
  logic [BIT_VEC_SIZE_LOG-1:0] upd_id_q, upd_id_d;
  logic [VAL_W-1:0]            upd_val_q, upd_val_d;

  logic [BIT_VEC_SIZE-1:0]     occ, le, hit, after;
  logic [BIT_VEC_SIZE_LOG-1:0] ins_id;
  logic [VAL_W-1:0]            ins_val;
  logic                        accept, present, full;
  slot_t                       new_slot;

  assign req_ready  = (state_q == S_IDLE);
  assign accept     = req_valid & req_ready;
  assign count      = count_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;

  // The insert source is the request in IDLE and the latched update in UPD_INS.
  assign ins_id   = (state_q == S_UPD_INS) ? upd_id_q  : req_id;
  assign ins_val  = (state_q == S_UPD_INS) ? upd_val_q : req_val;
  assign new_slot = slot_t'({ins_id, ins_val});
  assign present  = |hit;
  assign full     = (count_q == (BIT_VEC_SIZE_LOG+1)'(BIT_VEC_SIZE));

  // Per-slot compares. Because the list is sorted with empties at the tail,
  // le is a run of ones from slot 0; its length is the insert position, so
  // ties land after existing equal values.
  always_comb begin
    for (int i = 0; i < BIT_VEC_SIZE; i++) begin
      occ[i] = (slot_q[i].ptr != EMPTY_PTR);
      le[i]  = occ[i] && (slot_q[i].val <= ins_val);
      hit[i] = occ[i] && (slot_q[i].ptr == req_id);
    end
  end

  // after[i] = the deleted entry sits at or below slot i.
  always_comb begin
    logic run;
    run = 1'b0;
    for (int i = 0; i < BIT_VEC_SIZE; i++) begin
      run      = run | hit[i];
      after[i] = run;
    end
  end

  // Candidate list after an insert: keep the <= prefix, drop the new entry at
  // the first slot past it, shift everything else up by one.
  always_comb begin
    ins_slots[0] = le[0] ? slot_q[0] : new_slot;
    for (int i = 1; i < BIT_VEC_SIZE; i++) begin
      if (le[i])          ins_slots[i] = slot_q[i];
      else if (le[i-1])   ins_slots[i] = new_slot;
      else                ins_slots[i] = slot_q[i-1];
    end
  end

  // Candidate list after a delete: slots from the match onward pull down.
  always_comb begin
    for (int i = 0; i < BIT_VEC_SIZE - 1; i++) begin
      del_slots[i] = after[i] ? slot_q[i+1] : slot_q[i];
    end
    del_slots[BIT_VEC_SIZE-1] = after[BIT_VEC_SIZE-1] ? EMPTY_SLOT
                                                      : slot_q[BIT_VEC_SIZE-1];
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    count_d      = count_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    upd_id_d     = upd_id_q;
    upd_val_d    = upd_val_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (op_t'(req_op))
            OP_READ: begin
              resp_valid_d = 1'b1;
            end
            OP_INSERT: begin
              resp_valid_d = 1'b1;
              if (full || (req_id == EMPTY_PTR) || present) begin
                resp_err_d = 1'b1;
              end else begin
                slot_d  = ins_slots;
                count_d = count_q + 1'b1;
              end
            end
            OP_DELETE: begin
              resp_valid_d = 1'b1;
              if (!present) begin
                resp_err_d = 1'b1;
              end else begin
                slot_d  = del_slots;
                count_d = count_q - 1'b1;
              end
            end
            OP_UPDATE: begin
              if (!present) begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
              end else begin
                // Delete phase now; the re-insert cannot fail since the id
                // is gone and a slot was just freed.
                slot_d    = del_slots;
                count_d   = count_q - 1'b1;
                upd_id_d  = req_id;
                upd_val_d = req_val;
                state_d   = S_UPD_INS;
              end
            end
            default: ;
          endcase
        end
      end
      S_UPD_INS: begin
        slot_d       = ins_slots;
        count_d      = count_q + 1'b1;
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the slot array is reset along with the control state because the
  // list is visible on list_out immediately and must read as empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      upd_id_q     <= '0;
      upd_val_q    <= '0;
      for (int i = 0; i < BIT_VEC_SIZE; i++) slot_q[i] <= EMPTY_SLOT;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      upd_id_q     <= upd_id_d;
      upd_val_q    <= upd_val_d;
      for (int i = 0; i < BIT_VEC_SIZE; i++) slot_q[i] <= slot_d[i];
    end
  end

  for (genvar g = 0; g < BIT_VEC_SIZE; g++) begin : g_list
    assign list_out[g*SLOT_W +: SLOT_W] = slot_q[g];
  end

endmodule

// File: tb/tb_smbm_metric_list.sv
// ---------------------------------------------------------------------------
// tb_smbm_metric_list
//   Directed self-checking bench for smbm_metric_list. Each request is
//   presented for one clock; responses and list contents are sampled 1 time
//   unit after the rising edge and compared with hand-computed values.
// ---------------------------------------------------------------------------
module tb_smbm_metric_list;

  localparam int N   = 512;
  localparam int LG  = 9;
  localparam int VW  = 16;
  localparam int SW  = LG + VW;

  localparam logic [1:0] RD = 2'b00;
  localparam logic [1:0] IN = 2'b01;
  localparam logic [1:0] DL = 2'b10;
  localparam logic [1:0] UP = 2'b11;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [LG-1:0]   req_id;
  logic [VW-1:0]   req_val;
  logic [N*SW-1:0] list_out;
  logic [LG:0]     count;
  logic            resp_valid;
  logic            resp_err;

  int total = 0;
  int bad   = 0;

  smbm_metric_list #(.BIT_VEC_SIZE(N), .BIT_VEC_SIZE_LOG(LG), .VAL_W(VW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_id    (req_id),
    .req_val   (req_val),
    .list_out  (list_out),
    .count     (count),
    .resp_valid(resp_valid),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [LG-1:0] ptr_at(input int i);
    return list_out[i*SW+VW +: LG];
  endfunction

  function automatic logic [VW-1:0] val_at(input int i);
    return list_out[i*SW +: VW];
  endfunction

  // Presents one request for a single edge; returns 1 time unit after it.
  task automatic send(input logic [1:0] op, input int id, input int val);
    req_valid = 1'b1;
    req_op    = op;
    req_id    = id[LG-1:0];
    req_val   = val[VW-1:0];
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic check_slot(input string tag, input int i, input int p, input int v);
    check({tag, ".ptr"}, 32'(ptr_at(i)), p);
    check({tag, ".val"}, 32'(val_at(i)), v);
  endtask

  initial begin
    int nonempty;
    int errs;
    req_valid = 1'b0;
    req_op    = RD;
    req_id    = '0;
    req_val   = '0;
    do_reset();

    // Reset state and first read
    check("rst.ready", 32'(req_ready), 1);
    check("rst.count", 32'(count), 0);
    check("rst.resp_valid", 32'(resp_valid), 0);
    send(RD, 0, 0);
    check("read0.valid", 32'(resp_valid), 1);
    check("read0.err", 32'(resp_err), 0);
    nonempty = 0;
    for (int i = 0; i < N; i++) if (ptr_at(i) != 9'h1FF || val_at(i) != 0) nonempty++;
    check("read0.all_empty", nonempty, 0);
    @(posedge clk); #1;
    check("read0.pulse_drop", 32'(resp_valid), 0);

    // Inserts with a tie on val 30
    send(IN, 5, 30);  check("ins5.err", 32'(resp_err), 0);
    send(IN, 2, 10);  check("ins2.err", 32'(resp_err), 0);
    send(IN, 9, 30);  check("ins9.err", 32'(resp_err), 0);
    send(RD, 0, 0);
    check("read1.valid", 32'(resp_valid), 1);
    check_slot("l1.s0", 0, 2, 10);
    check_slot("l1.s1", 1, 5, 30);
    check_slot("l1.s2", 2, 9, 30);
    check("l1.s3.ptr", 32'(ptr_at(3)), 511);
    check("l1.count", 32'(count), 3);

    // Deletes
    send(DL, 5, 0);
    check("del5.valid", 32'(resp_valid), 1);
    check("del5.err", 32'(resp_err), 0);
    check_slot("l2.s0", 0, 2, 10);
    check_slot("l2.s1", 1, 9, 30);
    check_slot("l2.s2", 2, 511, 0);
    check("l2.count", 32'(count), 2);
    send(DL, 7, 0);
    check("del7.valid", 32'(resp_valid), 1);
    check("del7.err", 32'(resp_err), 1);
    check("del7.count", 32'(count), 2);
    check_slot("del7.s0", 0, 2, 10);

    // Update id2 -> 50: two cycles, ready low for one
    send(UP, 2, 50);
    check("upd2.ready_low", 32'(req_ready), 0);
    check("upd2.no_resp_yet", 32'(resp_valid), 0);
    @(posedge clk); #1;
    check("upd2.valid", 32'(resp_valid), 1);
    check("upd2.err", 32'(resp_err), 0);
    check("upd2.ready_back", 32'(req_ready), 1);
    check_slot("l3.s0", 0, 9, 30);
    check_slot("l3.s1", 1, 2, 50);
    check("l3.count", 32'(count), 2);
    send(UP, 3, 77);
    check("upd3.valid", 32'(resp_valid), 1);
    check("upd3.err", 32'(resp_err), 1);
    check("upd3.ready", 32'(req_ready), 1);
    check("upd3.count", 32'(count), 2);

    // Tie goes after the existing equal value
    send(IN, 6, 30);
    check_slot("tie.s1", 1, 6, 30);
    check_slot("tie.s2", 2, 2, 50);

    // Fill: ids 0..510 with descending vals, each lands at slot 0
    do_reset();
    errs = 0;
    for (int i = 0; i < N - 1; i++) begin
      send(IN, i, 510 - i);
      if (resp_valid !== 1'b1 || resp_err !== 1'b0) errs++;
    end
    check("fill.errs", errs, 0);
    check("fill.count", 32'(count), 511);
    check_slot("fill.s0", 0, 510, 0);
    check_slot("fill.s510", 510, 0, 510);
    check("fill.s511.ptr", 32'(ptr_at(511)), 511);
    send(IN, 511, 5);
    check("ins511.err", 32'(resp_err), 1);
    check("ins511.count", 32'(count), 511);
    send(IN, 0, 5);
    check("reins0.err", 32'(resp_err), 1);
    check("reins0.count", 32'(count), 511);

    // Max val goes to the tail
    send(DL, 300, 0);
    check("del300.err", 32'(resp_err), 0);
    check("del300.count", 32'(count), 510);
    send(IN, 300, 65535);
    check("insmax.err", 32'(resp_err), 0);
    check_slot("insmax.s510", 510, 300, 65535);
    check_slot("insmax.s209", 209, 301, 209);

    // Reset while in UPD_INS
    send(UP, 100, 7);
    check("rstmid.in_upd", 32'(req_ready), 0);
    rst = 1'b0;
    #1;
    check("rstmid.count", 32'(count), 0);
    check("rstmid.ready", 32'(req_ready), 1);
    check("rstmid.s0.ptr", 32'(ptr_at(0)), 511);
    check("rstmid.valid", 32'(resp_valid), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    errs = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0) errs++;
    end
    check("rstmid.no_resp", errs, 0);
    check("rstmid.count_after", 32'(count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
